// File: rtl/param_prescaler.sv
// ---------------------------------------------------------------------------
// param_prescaler
//   Programmable clock prescaler with a startup reset-hold sequencer.
//   After reset release the block spends one INIT cycle loading the ratio,
//   then RST_HOLD STARTUP cycles before releasing reset_out. The divider
//   runs in STARTUP and ACTIVE on enabled cycles, producing a 50% duty
//   divided clock with half-period (shadow+1) enabled cycles.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous active-low reset
//   en         : divider count enable
//   div_ratio  : requested half-period length minus one
//   clk_presc  : divided clock (registered)
//   tick       : one-cycle strobe after each 0->1 transition of clk_presc
//   reset_out  : downstream active-low reset, released after the hold
//   ratio_ack  : one-cycle strobe when a changed ratio is loaded
// ---------------------------------------------------------------------------
module param_prescaler #(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned RST_HOLD = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div_ratio,
  output logic             clk_presc,
  output logic             tick,
  output logic             reset_out,
  output logic             ratio_ack
);

  localparam int unsigned       HOLD_W    = 16;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_STARTUP = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DIV_W-1:0]   cnt;
  logic [DIV_W-1:0]   cnt_nxt;
  logic [DIV_W-1:0]   shadow;
  logic [DIV_W-1:0]   shadow_nxt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_cnt_nxt;
  logic               clk_presc_nxt;
  logic               tick_nxt;
  logic               reset_out_nxt;
  logic               ratio_ack_nxt;
  logic               run_c;
  logic               boundary_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:    state_nxt = ST_STARTUP;
      ST_STARTUP: if (hold_cnt == HOLD_LAST) state_nxt = ST_ACTIVE;
      ST_ACTIVE:  state_nxt = ST_ACTIVE;
      default:    state_nxt = ST_INIT;
    endcase
  end

  // Output / datapath next values; every output is registered below
  always_comb begin
    cnt_nxt       = cnt;
    shadow_nxt    = shadow;
    hold_cnt_nxt  = hold_cnt;
    clk_presc_nxt = clk_presc;
    tick_nxt      = 1'b0;
    ratio_ack_nxt = 1'b0;
    reset_out_nxt = reset_out;
    run_c         = en && (state != ST_INIT);
    boundary_c    = (cnt == shadow);

    case (state)
      ST_INIT: begin
        shadow_nxt    = div_ratio;
        cnt_nxt       = '0;
        hold_cnt_nxt  = '0;
        reset_out_nxt = 1'b0;
      end
      ST_STARTUP: begin
        hold_cnt_nxt = HOLD_W'(hold_cnt + HOLD_W'(1));
        if (hold_cnt == HOLD_LAST) reset_out_nxt = 1'b1;
      end
      ST_ACTIVE: begin
        reset_out_nxt = 1'b1;
      end
      default: begin
        reset_out_nxt = 1'b0;
      end
    endcase

    // Counter compares before incrementing, so an all-ones shadow never wraps
    if (run_c) begin
      if (boundary_c) begin
        cnt_nxt       = '0;
        clk_presc_nxt = ~clk_presc;
        tick_nxt      = ~clk_presc;
        shadow_nxt    = div_ratio;
        ratio_ack_nxt = (div_ratio != shadow);
      end else begin
        cnt_nxt = DIV_W'(cnt + DIV_W'(1));
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      shadow    <= '0;
      hold_cnt  <= '0;
      clk_presc <= 1'b0;
      tick      <= 1'b0;
      ratio_ack <= 1'b0;
      reset_out <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      shadow    <= shadow_nxt;
      hold_cnt  <= hold_cnt_nxt;
      clk_presc <= clk_presc_nxt;
      tick      <= tick_nxt;
      ratio_ack <= ratio_ack_nxt;
      reset_out <= reset_out_nxt;
    end
  end

endmodule

// File: tb/tb_param_prescaler.sv
// ---------------------------------------------------------------------------
// tb_param_prescaler
//   Directed plus randomized bench for param_prescaler. Two instances run in
//   parallel: defaults (8-bit ratio, 128-cycle hold) and a narrow one
//   (4-bit ratio, 1-cycle hold, ratio fixed at all ones). Each is compared
//   every cycle against a reference model that tracks edges since reset
//   release and the remaining enabled cycles of the current half-period.
// ---------------------------------------------------------------------------
module tb_param_prescaler;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] div_ratio;
  logic       clk_presc;
  logic       tick;
  logic       reset_out;
  logic       ratio_ack;

  logic       en4;
  logic [3:0] div4;
  logic       clk_presc4;
  logic       tick4;
  logic       reset_out4;
  logic       ratio_ack4;

  int n_checks;
  int n_pass;

  param_prescaler u_dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .div_ratio (div_ratio),
    .clk_presc (clk_presc),
    .tick      (tick),
    .reset_out (reset_out),
    .ratio_ack (ratio_ack)
  );

  param_prescaler #(.DIV_W(4), .RST_HOLD(1)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .en        (en4),
    .div_ratio (div4),
    .clk_presc (clk_presc4),
    .tick      (tick4),
    .reset_out (reset_out4),
    .ratio_ack (ratio_ack4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: edges counted since reset release; half-period tracked
  // as a length and a count of enabled cycles still remaining in it.
  typedef struct {
    int edges;
    int len;
    int rem;
    bit clkp;
    bit tick;
    bit ack;
    bit rout;
  } mdl_t;

  function automatic mdl_t mdl_clear();
    mdl_t m;
    m.edges = 0; m.len = 1; m.rem = 1;
    m.clkp = 1'b0; m.tick = 1'b0; m.ack = 1'b0; m.rout = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit en_i, int div, int hold);
    mdl_t n;
    n = m;
    n.tick = 1'b0;
    n.ack  = 1'b0;
    if (n.edges < 1000000) n.edges = n.edges + 1;
    if (n.edges == 1) begin
      n.len = div + 1;
      n.rem = n.len;
    end else if (en_i) begin
      n.rem = n.rem - 1;
      if (n.rem == 0) begin
        n.clkp = !n.clkp;
        n.tick = n.clkp;
        n.ack  = ((div + 1) != n.len);
        n.len  = div + 1;
        n.rem  = n.len;
      end
    end
    n.rout = (n.edges >= hold + 1);
    return n;
  endfunction

  mdl_t m8;
  mdl_t m4;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m8 <= mdl_clear();
      m4 <= mdl_clear();
    end else begin
      m8 <= mdl_step(m8, en, int'(div_ratio), 128);
      m4 <= mdl_step(m4, en4, int'(div4), 1);
    end
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Advance to the next falling edge and compare both DUTs with the models
  task automatic cycle();
    @(negedge clk);
    check_bit("clk_presc",  clk_presc,  m8.clkp);
    check_bit("tick",       tick,       m8.tick);
    check_bit("reset_out",  reset_out,  m8.rout);
    check_bit("ratio_ack",  ratio_ack,  m8.ack);
    check_bit("clk_presc4", clk_presc4, m4.clkp);
    check_bit("tick4",      tick4,      m4.tick);
    check_bit("reset_out4", reset_out4, m4.rout);
    check_bit("ratio_ack4", ratio_ack4, m4.ack);
  endtask

  task automatic check_all_low(input string tag);
    check_bit({tag, "_clk_presc"}, clk_presc,  1'b0);
    check_bit({tag, "_tick"},      tick,       1'b0);
    check_bit({tag, "_reset_out"}, reset_out,  1'b0);
    check_bit({tag, "_ratio_ack"}, ratio_ack,  1'b0);
    check_bit({tag, "_reset_out4"}, reset_out4, 1'b0);
    check_bit({tag, "_clk_presc4"}, clk_presc4, 1'b0);
  endtask

  initial begin
    int  highs;
    int  ticks;
    int  acks;
    logic held;

    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    en        = 1'b1;
    div_ratio = 8'd0;
    en4       = 1'b1;
    div4      = 4'hF;

    // Asynchronous reset assertion before any clock edge
    #2 reset = 1'b0;
    #1 check_all_low("rst_async");
    repeat (3) cycle();

    // Divide-by-2 with startup hold; reset_out released on edge 129
    reset = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      cycle();
      if (k == 2)   check_bit("first_toggle", clk_presc, 1'b1);
      if (k == 2)   check_bit("dut4_rout_e2", reset_out4, 1'b1);
      if (k == 128) check_bit("rout_edge128", reset_out, 1'b0);
      if (k == 129) check_bit("rout_edge129", reset_out, 1'b1);
    end

    // Ratio 3: 4 high / 4 low, one tick per 8 cycles
    div_ratio = 8'd3;
    repeat (16) cycle();
    highs = 0; ticks = 0; acks = 0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      highs += int'(clk_presc);
      ticks += int'(tick);
      acks  += int'(ratio_ack);
    end
    check_int("div3_high_cycles", highs, 8);
    check_int("div3_ticks", ticks, 2);
    check_int("div3_no_ack", acks, 0);

    // Mid half-period change 3 -> 1: one ack at the next boundary
    cycle();
    div_ratio = 8'd1;
    acks = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      acks += int'(ratio_ack);
    end
    check_int("change_ack_count", acks, 1);

    // Freeze for 5 cycles mid half-period
    div_ratio = 8'd5;
    repeat (9) cycle();
    en   = 1'b0;
    held = clk_presc;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_bit("freeze_hold", clk_presc, held);
      check_bit("freeze_tick", tick, 1'b0);
    end
    en = 1'b1;
    repeat (20) cycle();

    // Randomized enable and ratio changes
    for (int k = 0; k < 600; k++) begin
      en  = ($urandom_range(0, 7) != 0);
      en4 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) div_ratio = 8'($urandom_range(0, 6));
      cycle();
    end

    // All-ones ratio: 256-cycle half-period
    en = 1'b1; en4 = 1'b1;
    div_ratio = 8'hFF;
    repeat (600) cycle();

    // Reset pulse between edges while ACTIVE, then full sequence again
    div_ratio = 8'd2;
    #2 reset = 1'b0;
    #1 check_all_low("rst_midrun");
    #1 reset = 1'b1;
    for (int k = 1; k <= 135; k++) begin
      cycle();
      if (k == 128) check_bit("rerun_rout128", reset_out, 1'b0);
      if (k == 129) check_bit("rerun_rout129", reset_out, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
